mem_access_ctrl: RTL and testbench

MEM-stage data-memory access controller of the MIPS pipelined CPU, sitting between EXE2MEM and MEM2WB. It turns the EXE2MEM load/store controls into a req/ack transaction on a variable-latency data-memory port. It stalls the pipeline until the access completes and drives the MEM2WB inputs, inserting bubbles while waiting. It also detects misaligned word accesses and bus timeouts.

---
 rtl/mem_access_ctrl_pkg.sv | 19 +
 rtl/mem_timeout_cnt.sv | 37 +++
 rtl/mem_access_ctrl.sv | 117 +++++++++++
 tb/tb_mem_access_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared widths, FSM encoding and helpers for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_FILE_ADDR_LEN = 5;
    localparam int MEMC_TIMEOUT      = 16;

    typedef enum logic [1:0] {
        MEMC_IDLE = 2'd0,
        MEMC_BUSY = 2'd1,
        MEMC_DONE = 2'd2
    } memc_state_e;

    // A word access is misaligned when either of the two low address bits is set.
    function automatic logic is_misaligned(input logic op, input logic [1:0] addr_lo);
        return op && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Saturating wait counter for a pending memory request; expired_o flags the last allowed BUSY cycle.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Holds at LAST instead of wrapping so a stuck request stays expired.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: turns EXE2MEM load/store controls into a req/ack access,
// stalls the pipeline while waiting and feeds MEM2WB with bubbles until the data is ready.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = MEMC_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_EN_in,
    input  logic                         MEM_R_EN_in,
    input  logic                         MEM_W_EN_in,
    input  logic [WORD_LEN-1:0]          ALU_Result_in,
    input  logic [WORD_LEN-1:0]          ST_value_in,
    input  logic [REG_FILE_ADDR_LEN-1:0] Dest_in,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [WORD_LEN-1:0]          mem_addr,
    output logic [WORD_LEN-1:0]          mem_wdata,
    input  logic [WORD_LEN-1:0]          mem_rdata,
    input  logic                         mem_ack,
    output logic                         stall,
    output logic                         WB_EN,
    output logic                         Mem_Read_EN,
    output logic [WORD_LEN-1:0]          ALU_Result,
    output logic [WORD_LEN-1:0]          Data_memory,
    output logic [REG_FILE_ADDR_LEN-1:0] Dest,
    output logic                         mis_err,
    output logic                         bus_err
);

    memc_state_e         state_q, state_d;
    logic [WORD_LEN-1:0] rdata_q, rdata_d;
    logic                mis_err_q, mis_err_d;
    logic                bus_err_q, bus_err_d;
    logic                op, misal, expired, req_active, drop_ctrl;

    assign op    = MEM_R_EN_in | MEM_W_EN_in;
    assign misal = is_misaligned(op, ALU_Result_in[1:0]);

    mem_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clk_i     (clk),
        .rst_ni    (rst),
        .clear_i   (state_q != MEMC_BUSY),
        .en_i      (state_q == MEMC_BUSY),
        .expired_o (expired)
    );

    // Loads own the read data; a store ack leaves the last loaded value in place.
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        mis_err_d = 1'b0;
        bus_err_d = 1'b0;
        case (state_q)
            MEMC_IDLE: begin
                if (misal) begin
                    mis_err_d = 1'b1;
                end else if (op) begin
                    if (mem_ack) begin
                        if (MEM_R_EN_in) rdata_d = mem_rdata;
                        state_d = MEMC_DONE;
                    end else begin
                        state_d = MEMC_BUSY;
                    end
                end
            end
            MEMC_BUSY: begin
                if (mem_ack) begin
                    if (MEM_R_EN_in) rdata_d = mem_rdata;
                    state_d = MEMC_DONE;
                end else if (expired) begin
                    rdata_d   = '0;
                    bus_err_d = 1'b1;
                    state_d   = MEMC_DONE;
                end
            end
            default: state_d = MEMC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= MEMC_IDLE;
            rdata_q   <= '0;
            mis_err_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdata_q   <= rdata_d;
            mis_err_q <= mis_err_d;
            bus_err_q <= bus_err_d;
        end
    end

    // An asserted reset abandons any request immediately, even with upstream still frozen.
    assign req_active = rst && (((state_q == MEMC_IDLE) && op && !misal) || (state_q == MEMC_BUSY));
    assign drop_ctrl  = req_active || ((state_q == MEMC_IDLE) && misal);

    assign mem_req     = req_active;
    assign stall       = req_active;
    assign mem_we      = req_active && MEM_W_EN_in && !MEM_R_EN_in;
    assign mem_addr    = ALU_Result_in;
    assign mem_wdata   = ST_value_in;
    assign WB_EN       = WB_EN_in && !drop_ctrl;
    assign Mem_Read_EN = MEM_R_EN_in && !drop_ctrl;
    assign ALU_Result  = ALU_Result_in;
    assign Dest        = Dest_in;
    assign Data_memory = rdata_q;
    assign mis_err     = mis_err_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, reset corner case and randomized
// instruction stream checked against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0] ALU_Result_in, ST_value_in, mem_rdata;
    logic [4:0]  Dest_in;
    logic        mem_ack;
    logic        mem_req, mem_we, stall, WB_EN, Mem_Read_EN, mis_err, bus_err;
    logic [31:0] mem_addr, mem_wdata, ALU_Result, Data_memory;
    logic [4:0]  Dest;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(
        .TIMEOUT (T),
        .CNT_W   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .WB_EN_in      (WB_EN_in),
        .MEM_R_EN_in   (MEM_R_EN_in),
        .MEM_W_EN_in   (MEM_W_EN_in),
        .ALU_Result_in (ALU_Result_in),
        .ST_value_in   (ST_value_in),
        .Dest_in       (Dest_in),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .stall         (stall),
        .WB_EN         (WB_EN),
        .Mem_Read_EN   (Mem_Read_EN),
        .ALU_Result    (ALU_Result),
        .Data_memory   (Data_memory),
        .Dest          (Dest),
        .mis_err       (mis_err),
        .bus_err       (bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Presents one instruction until the DUT releases stall; memory acks on request cycle k.
    task automatic run_txn(input logic wb, input logic r, input logic w,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] dest, input int k,
                           input logic rand_rd, input logic [31:0] rd_fixed,
                           output int stalls, output logic o_wb, output logic o_mre,
                           output logic o_bus, output logic o_mis_first,
                           output logic [31:0] o_data, output logic [31:0] o_acked);
        int          j;
        logic        done;
        logic [31:0] rd;
        j = 0; done = 1'b0; stalls = 0;
        o_wb = 1'b0; o_mre = 1'b0; o_bus = 1'b0; o_mis_first = 1'b0;
        o_data = '0; o_acked = '0;
        while (!done && j <= T + 2) begin
            @(negedge clk);
            WB_EN_in = wb; MEM_R_EN_in = r; MEM_W_EN_in = w;
            ALU_Result_in = addr; ST_value_in = sdata; Dest_in = dest;
            rd = rand_rd ? $urandom : rd_fixed;
            mem_rdata = rd;
            mem_ack = (j == k);
            if (j == k) o_acked = rd;
            #1;
            if (j == 0) o_mis_first = mis_err;
            chk("alu_pass", ALU_Result, addr);
            chk("dest_pass", {27'd0, Dest}, {27'd0, dest});
            if (stall) begin
                chk("req_in_stall", {31'd0, mem_req}, 32'd1);
                chk("we_in_stall", {31'd0, mem_we}, {31'd0, w & ~r});
                chk("addr_stable", mem_addr, addr);
                chk("wdata_stable", mem_wdata, sdata);
                chk("bubble_wb", {31'd0, WB_EN}, 32'd0);
                chk("bubble_mre", {31'd0, Mem_Read_EN}, 32'd0);
                chk("bus_err_in_stall", {31'd0, bus_err}, 32'd0);
                j++;
            end else begin
                chk("no_req_when_free", {31'd0, mem_req}, 32'd0);
                stalls = j; o_wb = WB_EN; o_mre = Mem_Read_EN;
                o_bus = bus_err; o_data = Data_memory;
                done = 1'b1;
            end
        end
        if (!done) begin
            failures++;
            $display("FAIL txn_bound actual=stuck_in_stall required=release_within_%0d", T + 2);
        end
    endtask

    typedef struct {
        logic        wb, r, w;
        logic [31:0] addr, sdata, rdata;
        logic [4:0]  dest;
        int          k;
        int          exp_stall;
        logic        exp_wb, exp_mre, exp_bus, exp_mis;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int          st;
        logic        owb, omre, obus, omis;
        logic [31:0] odata, oack;
        logic [31:0] model_rd;
        logic        prev_mis;

        rst = 1'b0;
        WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0;
        ALU_Result_in = '0; ST_value_in = '0; Dest_in = '0;
        mem_rdata = '0; mem_ack = 0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_data", Data_memory, 32'd0);
        chk("rst_mis_err", {31'd0, mis_err}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        #11 rst = 1'b1;

        //          wb r  w  addr          sdata         rdata         dest k   stall wb mre bus mis data
        vecs[0]  = '{1, 1, 0, 32'h40,       32'h0,        32'h12345678, 5,   0,  1,    1, 1,  0,  0, 32'h12345678};
        vecs[1]  = '{0, 0, 1, 32'h80,       32'hCAFEF00D, 32'hDEADBEEF, 0,   3,  4,    0, 0,  0,  0, 32'h12345678};
        vecs[2]  = '{1, 1, 0, 32'h41,       32'h0,        32'hAAAA0000, 7,  -1,  0,    0, 0,  0,  0, 32'h12345678};
        vecs[3]  = '{1, 0, 0, 32'h1234,     32'h0,        32'h0,        8,  -1,  0,    1, 0,  0,  1, 32'h12345678};
        vecs[4]  = '{1, 1, 0, 32'h44,       32'h0,        32'hFFFFFFFF, 3,   5,  5,    1, 1,  1,  0, 32'h0};
        vecs[5]  = '{1, 1, 0, 32'h48,       32'h0,        32'h11112222, 9,   1,  2,    1, 1,  0,  0, 32'h11112222};
        vecs[6]  = '{1, 0, 0, 32'h99,       32'h0,        32'h0,        10, -1,  0,    1, 0,  0,  0, 32'h11112222};
        vecs[7]  = '{1, 1, 0, 32'h4C,       32'h0,        32'h33334444, 11,  1,  2,    1, 1,  0,  0, 32'h33334444};
        vecs[8]  = '{1, 1, 1, 32'h50,       32'h0BADF00D, 32'h55556666, 12,  2,  3,    1, 1,  0,  0, 32'h55556666};
        vecs[9]  = '{0, 0, 1, 32'h54,       32'h01020304, 32'h99999999, 0,   4,  5,    0, 0,  0,  0, 32'h55556666};
        vecs[10] = '{0, 0, 1, 32'h58,       32'h05060708, 32'h0,        0,  -1,  5,    0, 0,  1,  0, 32'h0};

        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].wb, vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].sdata,
                    vecs[i].dest, vecs[i].k, 1'b0, vecs[i].rdata,
                    st, owb, omre, obus, omis, odata, oack);
            chk($sformatf("vec%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_wb", i), {31'd0, owb}, {31'd0, vecs[i].exp_wb});
            chk($sformatf("vec%0d_mre", i), {31'd0, omre}, {31'd0, vecs[i].exp_mre});
            chk($sformatf("vec%0d_bus", i), {31'd0, obus}, {31'd0, vecs[i].exp_bus});
            chk($sformatf("vec%0d_mis", i), {31'd0, omis}, {31'd0, vecs[i].exp_mis});
            chk($sformatf("vec%0d_data", i), odata, vecs[i].exp_data);
        end

        // Reset asserted between edges while a load waits in BUSY.
        run_txn(1, 1, 0, 32'h5C, 0, 3, 0, 1'b0, 32'hABCD0123, st, owb, omre, obus, omis, odata, oack);
        @(negedge clk);
        WB_EN_in = 1; MEM_R_EN_in = 1; MEM_W_EN_in = 0; ALU_Result_in = 32'h60; Dest_in = 5'd4; mem_ack = 0;
        #1 chk("busy_first_stall", {31'd0, stall}, 32'd1);
        @(negedge clk);
        #1 chk("busy_second_stall", {31'd0, stall}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_data", Data_memory, 32'd0);
        @(negedge clk);
        MEM_R_EN_in = 0; WB_EN_in = 0;
        #2 rst = 1'b1;
        run_txn(1, 1, 0, 32'h64, 0, 6, 0, 1'b0, 32'h77778888, st, owb, omre, obus, omis, odata, oack);
        chk("postrst_stall", 32'(st), 32'd1);
        chk("postrst_wb", {31'd0, owb}, 32'd1);
        chk("postrst_data", odata, 32'h77778888);

        model_rd = 32'h77778888;
        prev_mis = 1'b0;
        for (int n = 0; n < 200; n++) begin
            logic        rw, rr, ww, op, mis;
            logic [31:0] ra;
            int          rk, e_stall;
            logic        e_wb, e_mre, e_bus;
            case ($urandom % 4)
                0:       begin rr = 0; ww = 0; end
                1:       begin rr = 1; ww = 0; end
                2:       begin rr = 0; ww = 1; end
                default: begin rr = 1; ww = 1; end
            endcase
            rw = 1'($urandom);
            ra = $urandom;
            if (($urandom % 5) != 0) ra[1:0] = 2'b00;
            else if (ra[1:0] == 2'b00) ra[0] = 1'b1;
            op  = rr | ww;
            mis = op && (ra[1:0] != 2'b00);
            rk  = int'($urandom_range(0, T + 2));
            if (rk == T + 2 || !op || mis) rk = -1;
            run_txn(rw, rr, ww, ra, $urandom, 5'($urandom), rk, 1'b1, 32'h0,
                    st, owb, omre, obus, omis, odata, oack);
            if (!op) begin
                e_stall = 0; e_wb = rw; e_mre = 0; e_bus = 0;
            end else if (mis) begin
                e_stall = 0; e_wb = 0; e_mre = 0; e_bus = 0;
            end else if (rk >= 0 && rk <= T) begin
                e_stall = rk + 1; e_wb = rw; e_mre = rr; e_bus = 0;
                if (rr) model_rd = oack;
            end else begin
                e_stall = T + 1; e_wb = rw; e_mre = rr; e_bus = 1;
                model_rd = '0;
            end
            chk("rnd_stall", 32'(st), 32'(e_stall));
            chk("rnd_wb", {31'd0, owb}, {31'd0, e_wb});
            chk("rnd_mre", {31'd0, omre}, {31'd0, e_mre});
            chk("rnd_bus", {31'd0, obus}, {31'd0, e_bus});
            chk("rnd_mis", {31'd0, omis}, {31'd0, prev_mis});
            chk("rnd_data", odata, model_rd);
            prev_mis = mis;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
